// File: rtl/comparator_if.sv
// Operand/result bundle for the registered magnitude comparator.
// COMP_MINMAX_EN adds the max_out/min_out result fields.
interface comparator_if #(
    parameter int BITS  = 4,
    parameter int CNT_W = 8
) ();
    logic [BITS-1:0]  in1;
    logic [BITS-1:0]  in2;
    logic             in_valid;
    logic             cnt_clr;
    logic             Lt;
    logic             Gt;
    logic             Et;
    logic             out_valid;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] et_cnt;
`ifdef COMP_MINMAX_EN
    logic [BITS-1:0]  max_out;
    logic [BITS-1:0]  min_out;

    modport master (
        output in1, in2, in_valid, cnt_clr,
        input  Lt, Gt, Et, out_valid, lt_cnt, gt_cnt, et_cnt, max_out, min_out
    );
    modport slave (
        input  in1, in2, in_valid, cnt_clr,
        output Lt, Gt, Et, out_valid, lt_cnt, gt_cnt, et_cnt, max_out, min_out
    );
`else
    modport master (
        output in1, in2, in_valid, cnt_clr,
        input  Lt, Gt, Et, out_valid, lt_cnt, gt_cnt, et_cnt
    );
    modport slave (
        input  in1, in2, in_valid, cnt_clr,
        output Lt, Gt, Et, out_valid, lt_cnt, gt_cnt, et_cnt
    );
`endif
endinterface

// File: rtl/comparator.sv
// Registered magnitude comparator with one-hot flags and saturating outcome counters.
// Define COMP_MINMAX_EN to also register max_out/min_out.
module comparator #(
    parameter int BITS        = 4,
    parameter int SIGNED_MODE = 0,
    parameter int CNT_W       = 8
) (
    input logic          clk,
    input logic          rst,
    comparator_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             a_lt_b;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             lt_q;
    logic             gt_q;
    logic             et_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] lt_cnt_q;
    logic [CNT_W-1:0] gt_cnt_q;
    logic [CNT_W-1:0] et_cnt_q;

    // Equality is bitwise in both modes; only the ordering depends on signedness.
    always_comb begin
        a_eq_b = (bus.in1 == bus.in2);
        if (SIGNED_MODE != 0) begin
            a_lt_b = ($signed(bus.in1) < $signed(bus.in2));
        end else begin
            a_lt_b = (bus.in1 < bus.in2);
        end
        a_gt_b = !a_lt_b && !a_eq_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            et_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                lt_q <= a_lt_b;
                gt_q <= a_gt_b;
                et_q <= a_eq_b;
            end
        end
    end

    // Clear wins over a same-cycle increment; that sample goes uncounted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lt_cnt_q <= '0;
            gt_cnt_q <= '0;
            et_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            lt_cnt_q <= '0;
            gt_cnt_q <= '0;
            et_cnt_q <= '0;
        end else if (bus.in_valid) begin
            if (a_lt_b && (lt_cnt_q != CNT_MAX)) lt_cnt_q <= lt_cnt_q + CNT_W'(1);
            if (a_gt_b && (gt_cnt_q != CNT_MAX)) gt_cnt_q <= gt_cnt_q + CNT_W'(1);
            if (a_eq_b && (et_cnt_q != CNT_MAX)) et_cnt_q <= et_cnt_q + CNT_W'(1);
        end
    end

    assign bus.Lt        = lt_q;
    assign bus.Gt        = gt_q;
    assign bus.Et        = et_q;
    assign bus.out_valid = out_valid_q;
    assign bus.lt_cnt    = lt_cnt_q;
    assign bus.gt_cnt    = gt_cnt_q;
    assign bus.et_cnt    = et_cnt_q;

`ifdef COMP_MINMAX_EN
    logic [BITS-1:0] max_q;
    logic [BITS-1:0] min_q;

    // On equality both outputs take in1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            min_q <= '0;
        end else if (bus.in_valid) begin
            max_q <= a_lt_b ? bus.in2 : bus.in1;
            min_q <= a_gt_b ? bus.in2 : bus.in1;
        end
    end

    assign bus.max_out = max_q;
    assign bus.min_out = min_q;
`endif
endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: unsigned, signed and narrow-counter instances.
module tb_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    comparator_if #(.BITS(4), .CNT_W(8)) if_u ();
    comparator_if #(.BITS(4), .CNT_W(8)) if_s ();
    comparator_if #(.BITS(4), .CNT_W(2)) if_c ();

    comparator #(.BITS(4), .SIGNED_MODE(0), .CNT_W(8)) dut_u (.clk(clk), .rst(rst), .bus(if_u));
    comparator #(.BITS(4), .SIGNED_MODE(1), .CNT_W(8)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    comparator #(.BITS(4), .SIGNED_MODE(0), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    typedef struct packed {
        logic [2:0] flags;
        logic [3:0] mx;
        logic [3:0] mn;
    } exp_t;

    exp_t sb[$];

    // Independent reference: flags ordered {Lt,Gt,Et}
    function automatic logic [2:0] ref_flags(input logic [3:0] a, input logic [3:0] b, input bit sgn);
        int ia;
        int ib;
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        if (ia < ib) return 3'b100;
        if (ia > ib) return 3'b010;
        return 3'b001;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        if_u.in1 = 0; if_u.in2 = 0; if_u.in_valid = 0; if_u.cnt_clr = 0;
        if_s.in1 = 0; if_s.in2 = 0; if_s.in_valid = 0; if_s.cnt_clr = 0;
        if_c.in1 = 0; if_c.in2 = 0; if_c.in_valid = 0; if_c.cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        #1;
        total++;
        if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b need 0000", {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid});
        end
        total++;
        if ({if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt} !== 24'd0) begin
            bad++; $display("FAIL reset_cnt: got %h need 0", {if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt});
        end
`ifdef COMP_MINMAX_EN
        total++;
        if ({if_u.max_out, if_u.min_out} !== 8'h00) begin
            bad++; $display("FAIL reset_minmax: got %h need 00", {if_u.max_out, if_u.min_out});
        end
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== 4'b0000) begin
            bad++; $display("FAIL idle_after_reset: got %b need 0000", {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid});
        end
    endtask

    task automatic test_unsigned();
        logic [3:0] ta [6] = '{4'd3, 4'd7, 4'd8, 4'd0, 4'd15, 4'd5};
        logic [3:0] tb_ [6] = '{4'd7, 4'd7, 4'd2, 4'd0, 4'd14, 4'd10};
        logic [2:0] tf [6] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b010, 3'b100};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_u.in1 = ta[i]; if_u.in2 = tb_[i]; if_u.in_valid = 1'b1;
            sb.push_back('{flags: tf[i], mx: 4'd0, mn: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== {e.flags, 1'b1}) begin
                bad++; $display("FAIL unsigned_%0d: got %b need %b", i, {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid}, {e.flags, 1'b1});
            end
        end
        @(negedge clk);
        if_u.in_valid = 1'b0;
        if_u.in1 = 4'd15; if_u.in2 = 4'd0;
        @(posedge clk); #1;
        total++;
        if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== 4'b1000) begin
            bad++; $display("FAIL hold_after_drop: got %b need 1000", {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid});
        end
        total++;
        if ({if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt} !== {8'd2, 8'd2, 8'd2}) begin
            bad++; $display("FAIL counts_unsigned: got %0d/%0d/%0d need 2/2/2", if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt);
        end
    endtask

    task automatic test_signed();
        logic [3:0] ta [3] = '{4'd8, 4'd7, 4'd15};
        logic [3:0] tb_ [3] = '{4'd2, 4'd15, 4'd15};
        logic [2:0] tf [3] = '{3'b100, 3'b010, 3'b001};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_s.in1 = ta[i]; if_s.in2 = tb_[i]; if_s.in_valid = 1'b1;
            sb.push_back('{flags: tf[i], mx: 4'd0, mn: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({if_s.Lt, if_s.Gt, if_s.Et, if_s.out_valid} !== {e.flags, 1'b1}) begin
                bad++; $display("FAIL signed_%0d: got %b need %b", i, {if_s.Lt, if_s.Gt, if_s.Et, if_s.out_valid}, {e.flags, 1'b1});
            end
        end
        @(negedge clk);
        if_s.in_valid = 1'b0;
    endtask

    task automatic test_saturate();
        logic [1:0] need;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if_c.in1 = 4'd1; if_c.in2 = 4'd0; if_c.in_valid = 1'b1;
            @(posedge clk); #1;
            need = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
            total++;
            if (if_c.gt_cnt !== need || if_c.Gt !== 1'b1) begin
                bad++; $display("FAIL sat_%0d: got gt_cnt=%0d Gt=%b need %0d/1", i, if_c.gt_cnt, if_c.Gt, need);
            end
        end
        @(negedge clk);
        if_c.in1 = 4'd0; if_c.in2 = 4'd1; if_c.cnt_clr = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({if_c.lt_cnt, if_c.gt_cnt, if_c.et_cnt} !== 6'd0 || {if_c.Lt, if_c.Gt, if_c.Et, if_c.out_valid} !== 4'b1001) begin
            bad++; $display("FAIL clr_priority: got cnt=%h flags=%b need 0/1001", {if_c.lt_cnt, if_c.gt_cnt, if_c.et_cnt}, {if_c.Lt, if_c.Gt, if_c.Et, if_c.out_valid});
        end
        @(negedge clk);
        if_c.cnt_clr = 1'b0;
        @(posedge clk); #1;
        total++;
        if (if_c.lt_cnt !== 2'd1) begin
            bad++; $display("FAIL count_after_clr: got %0d need 1", if_c.lt_cnt);
        end
        @(negedge clk);
        if_c.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lt_e = 2, gt_e = 2, et_e = 2;
        logic [2:0] last = 3'b100;
        logic [2:0] f;
        logic v, c;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) == 0);
            if_u.in1 = 4'($urandom_range(0, 15));
            if_u.in2 = ($urandom_range(0, 3) == 0) ? if_u.in1 : 4'($urandom_range(0, 15));
            if_u.in_valid = v; if_u.cnt_clr = c;
            f = ref_flags(if_u.in1, if_u.in2, 1'b0);
            if (v) last = f;
            if (c) begin
                lt_e = 0; gt_e = 0; et_e = 0;
            end else if (v) begin
                if (f[2] && lt_e < 255) lt_e++;
                if (f[1] && gt_e < 255) gt_e++;
                if (f[0] && et_e < 255) et_e++;
            end
            sb.push_back('{flags: last, mx: 4'd0, mn: 4'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== {e.flags, v}) begin
                bad++; $display("FAIL b2b_flags_%0d: got %b need %b", i, {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid}, {e.flags, v});
            end
            total++;
            if (if_u.lt_cnt !== 8'(lt_e) || if_u.gt_cnt !== 8'(gt_e) || if_u.et_cnt !== 8'(et_e)) begin
                bad++; $display("FAIL b2b_cnt_%0d: got %0d/%0d/%0d need %0d/%0d/%0d", i, if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt, lt_e, gt_e, et_e);
            end
        end
        @(negedge clk);
        if_u.in_valid = 1'b0; if_u.cnt_clr = 1'b0;
    endtask

`ifdef COMP_MINMAX_EN
    task automatic test_minmax();
        logic [3:0] ta [2] = '{4'd12, 4'd6};
        logic [3:0] tb_ [2] = '{4'd4, 4'd6};
        logic [3:0] tx [2] = '{4'd12, 4'd6};
        logic [3:0] tn [2] = '{4'd4, 4'd6};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if_u.in1 = ta[i]; if_u.in2 = tb_[i]; if_u.in_valid = 1'b1;
            sb.push_back('{flags: 3'b000, mx: tx[i], mn: tn[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (if_u.max_out !== e.mx || if_u.min_out !== e.mn) begin
                bad++; $display("FAIL minmax_%0d: got %0d/%0d need %0d/%0d", i, if_u.max_out, if_u.min_out, e.mx, e.mn);
            end
        end
        @(negedge clk);
        if_u.in_valid = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        @(negedge clk);
        if_u.in1 = 4'd2; if_u.in2 = 4'd5; if_u.in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (if_u.out_valid !== 1'b1) begin
            bad++; $display("FAIL pre_rst_valid: got %b need 1", if_u.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== 4'b0000 || {if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt} !== 24'd0) begin
            bad++; $display("FAIL async_rst: got flags=%b cnt=%h need 0000/0", {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid}, {if_u.lt_cnt, if_u.gt_cnt, if_u.et_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        if_u.in1 = 4'd9; if_u.in2 = 4'd9; if_u.in_valid = 1'b1;
        sb.push_back('{flags: 3'b001, mx: 4'd9, mn: 4'd9});
        @(posedge clk); #1;
        total++;
        if ({if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid} !== {sb[0].flags, 1'b1} || if_u.et_cnt !== 8'd1) begin
            bad++; $display("FAIL post_rst_eq: got flags=%b et_cnt=%0d need %b1/1", {if_u.Lt, if_u.Gt, if_u.Et, if_u.out_valid}, if_u.et_cnt, sb[0].flags);
        end
        void'(sb.pop_front());
        @(negedge clk);
        if_u.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_saturate();
        test_back_to_back();
`ifdef COMP_MINMAX_EN
        test_minmax();
`endif
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
